// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and constants for the sequential multiplier
// Purpose: FSM state encoding and default operand width for mul_seq.
// Ports: none (package).
package mul_pkg;

  localparam int MUL_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mul_add.sv
// rtl/mul_add.sv - combinational N-bit adder with carry-out
// Purpose: the single wide adder used by mul_seq for acc + mcand.
// Ports:
//   a, b   in  N  addends
//   sum    out N  a + b, truncated to N bits
//   cout   out 1  carry out of the top bit
module mul_add #(
  parameter int N = 64
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - sequential unsigned shift-and-add multiplier
// Purpose: one 2*WIDTH-bit product per transaction, one add per clock.
// Optional feature macro: MUL_SEQ_EARLY_EXIT_EN (finish as soon as the
// remaining multiplier bits are all zero).
// Ports:
//   clk        in  1          rising-edge clock
//   rst_n      in  1          asynchronous active-low reset
//   in_valid   in  1          operands a, b valid
//   in_ready   out 1          block can accept operands (IDLE only)
//   a          in  WIDTH      multiplicand, unsigned
//   b          in  WIDTH      multiplier, unsigned
//   out_valid  out 1          product valid (DONE)
//   out_ready  in  1          consumer accepts product
//   product    out 2*WIDTH    a*b, unsigned
//   busy       out 1          high in RUN or DONE
module mul_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  mul_state_t     state;
  logic [PW-1:0]  mcand;
  logic [PW-1:0]  acc;
  logic [PW-1:0]  sum;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]  cnt;
  logic           last_iter;
  mul_state_t     start_state;
  // Carry cannot be set for valid operands: a*b always fits in 2*WIDTH bits.
  logic           unused_carry;

  mul_add #(.N(PW)) u_add (
    .a    (acc),
    .b    (mcand),
    .sum  (sum),
    .cout (unused_carry)
  );

`ifdef MUL_SEQ_EARLY_EXIT_EN
  // Stop once the multiplier bits left after this shift are all zero;
  // no further iteration could change acc.
  assign last_iter   = (cnt == CNT_LAST) || (mplier[WIDTH-1:1] == '0);
  assign start_state = (b == '0) ? DONE : RUN;
`else
  assign last_iter   = (cnt == CNT_LAST);
  assign start_state = RUN;
`endif

  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign product   = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            state  <= start_state;
          end
        end
        RUN: begin
          if (mplier[0]) begin
            acc <= sum;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (last_iter) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// tb/tb_mul_seq.sv - scoreboard testbench for mul_seq
`timescale 1ns/1ps
module tb_mul_seq;

  localparam int W = 32;

`ifdef MUL_SEQ_EARLY_EXIT_EN
  localparam int LAT_B5  = 3;
  localparam int LAT_B1  = 1;
  localparam int LAT_B0  = 0;
  localparam int LAT_B9  = 4;
  localparam int LAT_B4  = 3;
`else
  localparam int LAT_B5  = 32;
  localparam int LAT_B1  = 32;
  localparam int LAT_B0  = 32;
  localparam int LAT_B9  = 32;
  localparam int LAT_B4  = 32;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     a = '0;
  logic [W-1:0]     b = '0;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   product;
  logic             busy;

  logic             fixed_ready = 1'b1;
  logic             rand_mode = 1'b0;
  logic             rnd_bit = 1'b0;

  int               n_cmp = 0;
  int               n_bad = 0;
  logic [2*W-1:0]   exp_q[$];

  assign out_ready = rand_mode ? rnd_bit : fixed_ready;

  always #5 clk = ~clk;

  mul_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #2;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  // Monitor: pops the scoreboard on each handshake, checks hold while stalled.
  logic             stalled = 1'b0;
  logic [2*W-1:0]   held = '0;
  always @(negedge clk) begin
    #1;
    if (rst_n && out_valid) begin
      if (stalled) chk("product_hold", product, held);
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: got 0x%0h expected no output", product);
        end else begin
          chk("product", product, exp_q.pop_front());
        end
        stalled = 1'b0;
      end else begin
        held    = product;
        stalled = 1'b1;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [63:0] exp, input int lat);
    int g;
    int l;
    g = 0;
    l = 0;
    @(negedge clk);
    while (!in_ready && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready 0 expected 1");
      return;
    end
    a = x;
    b = y;
    in_valid = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    in_valid = 1'b0;
    if (lat >= 0) begin
      while (!out_valid && l < 100) begin
        @(negedge clk);
        l++;
      end
      chk("latency", 64'(l), 64'(lat));
    end
  endtask

  initial begin
    logic [W-1:0] rx;
    logic [W-1:0] ry;
    int g;

    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_product", product, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    send(32'd3, 32'd5, 64'h0000_0000_0000_000F, LAT_B5);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 32);
    send(32'h0000_1234, 32'd1, 64'h0000_0000_0000_1234, LAT_B1);
    send(32'h0000_ABCD, 32'd0, 64'h0, LAT_B0);

    // Backpressure: product held, no accept while stalled.
    @(negedge clk);
    fixed_ready = 1'b0;
    send(32'd7, 32'd9, 64'd63, LAT_B9);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_busy", 64'(busy), 64'd1);
    end
    @(negedge clk);
    fixed_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("drain_in_ready", 64'(in_ready), 64'd1);

    // Reset in the middle of RUN discards the transaction.
    send(32'd11, 32'hF000_0001, 64'h0000_000A_5000_000B, -1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("midrst_hold_valid", 64'(out_valid), 64'd0);
    end
    rst_n = 1'b1;
    #1;
    chk("midrst_release_in_ready", 64'(in_ready), 64'd1);
    send(32'd2, 32'd4, 64'd8, LAT_B4);

    // Back-to-back random pairs with random consumer backpressure.
    rand_mode = 1'b1;
    for (int i = 0; i < 100; i++) begin
      rx = $urandom;
      ry = $urandom;
      send(rx, ry, 64'(rx) * 64'(ry), -1);
    end
    g = 0;
    while (exp_q.size() != 0 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    rand_mode = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
